// File: rtl/mesh_pkg.sv
// Shared types and helpers for the sort/route mesh PE: run phases, sort opcodes,
// neighbour directions, key ordering and key-to-target-coordinate splits.
package mesh_pkg;

    typedef enum logic [2:0] {
        IDLE,
        SORT,
        ROW_ALIGN,
        COL_ALIGN,
        DONE
    } phase_t;

    // Sort instruction is {op[1:0], dir[1:0]}.
    localparam logic [1:0] OP_HOLD       = 2'b00;
    localparam logic [1:0] OP_TAKE_IF_LT = 2'b01;  // take when own < neighbour
    localparam logic [1:0] OP_TAKE_IF_GT = 2'b10;  // take when own > neighbour
    localparam logic [1:0] OP_TAKE       = 2'b11;

    localparam logic [1:0] DIR_L = 2'b00;
    localparam logic [1:0] DIR_R = 2'b01;
    localparam logic [1:0] DIR_U = 2'b10;
    localparam logic [1:0] DIR_D = 2'b11;

    // Ordering on {~valid,key}: empty slots sort after every valid key and tie with each other.
    function automatic logic key_lt(input logic a_valid, input logic [31:0] a_key,
                                    input logic b_valid, input logic [31:0] b_key);
        if (a_valid && b_valid)
            return a_key < b_key;
        return a_valid && !b_valid;
    endfunction

    function automatic logic [31:0] tgt_row(input logic [31:0] key, input int col_bits);
        return key >> col_bits;
    endfunction

    function automatic logic [31:0] tgt_col(input logic [31:0] key, input int col_bits);
        return key & ((32'd1 << col_bits) - 32'd1);
    endfunction

endpackage

// File: rtl/mesh_pe_phase_ctrl.sv
// Run sequencer for one mesh PE: phase FSM, shared phase counter, step parity,
// and the busy/done/inst_addr status derived from them.
module mesh_pe_phase_ctrl
    import mesh_pkg::*;
#(
    parameter int ROWS        = 32,
    parameter int COLS        = 32,
    parameter int SORT_CYCLES = 222,
    parameter int CNT_W       = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    output phase_t           phase,
    output logic             parity,
    output logic             start_ok,
    output logic             busy,
    output logic             done,
    output logic [CNT_W-1:0] inst_addr
);

    phase_t           phase_nxt;
    logic [CNT_W-1:0] cnt, cnt_nxt;

    // NOTE: reset here is synchronous, so it sits inside the clocked branch; state uses <= only.
    always_ff @(posedge clk) begin
        if (rst) begin
            phase <= IDLE;
            cnt   <= '0;
        end else begin
            phase <= phase_nxt;
            cnt   <= cnt_nxt;
        end
    end

    // NOTE: every output of this block gets a default first, so no path can infer a latch.
    always_comb begin
        phase_nxt = phase;
        cnt_nxt   = cnt + CNT_W'(1);
        case (phase)
            IDLE: begin
                cnt_nxt = '0;
                if (start) phase_nxt = SORT;
            end
            SORT: if (cnt == CNT_W'(SORT_CYCLES - 1)) begin
                phase_nxt = ROW_ALIGN;
                cnt_nxt   = '0;
            end
            ROW_ALIGN: if (cnt == CNT_W'(ROWS - 1)) begin
                phase_nxt = COL_ALIGN;
                cnt_nxt   = '0;
            end
            COL_ALIGN: if (cnt == CNT_W'(COLS - 1)) begin
                phase_nxt = DONE;
                cnt_nxt   = '0;
            end
            default: begin
                phase_nxt = IDLE;
                cnt_nxt   = '0;
            end
        endcase
    end

    assign parity    = cnt[0];
    assign start_ok  = (phase == IDLE) && start;
    assign busy      = (phase == SORT) || (phase == ROW_ALIGN) || (phase == COL_ALIGN);
    assign done      = (phase == DONE);
    assign inst_addr = (phase == SORT) ? cnt : '0;

endmodule

// File: rtl/mesh_sort_pe.sv
// One PE of a ROWS x COLS sort/route mesh: compare-exchange sort, then parity-scheduled
// row/column alignment and delivery. Optional stall counter: define MESH_PE_STALL_CNT_EN.
module mesh_sort_pe
    import mesh_pkg::*;
#(
    parameter int ROWS        = 32,
    parameter int COLS        = 32,
    parameter int ROW         = 0,
    parameter int COL         = 0,
    parameter int KEY_W       = 10,
    parameter int DATA_W      = 10,
    parameter int SORT_CYCLES = 222,
    parameter int CNT_W       = 8
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    start,
    input  logic                    load_valid,
    input  logic [KEY_W-1:0]        load_key,
    input  logic [DATA_W-1:0]       load_data,
    input  logic [3:0]              inst,
    output logic [CNT_W-1:0]        inst_addr,
    input  logic [KEY_W+DATA_W:0]   i_l,
    input  logic [KEY_W+DATA_W:0]   i_r,
    input  logic [KEY_W+DATA_W:0]   i_u,
    input  logic [KEY_W+DATA_W:0]   i_d,
    output logic [KEY_W+DATA_W:0]   o_pkt,
    output logic                    busy,
    output logic                    done,
    output logic                    res_valid,
    output logic [KEY_W+DATA_W:0]   res_pkt,
    output logic                    conflict
`ifdef MESH_PE_STALL_CNT_EN
    ,
    output logic [15:0]             stall_cnt
`endif
);

    // Packet layout depends on KEY_W/DATA_W, so the struct lives with the parameters.
    typedef struct packed {
        logic              valid;
        logic [KEY_W-1:0]  key;
        logic [DATA_W-1:0] data;
    } pkt_t;

    localparam int               COL_BITS = $clog2(COLS);
    localparam logic [31:0]      ROW_U    = 32'(ROW);
    localparam logic [31:0]      COL_U    = 32'(COL);
    localparam logic [KEY_W-1:0] SELF_KEY = KEY_W'(ROW * COLS + COL);

    phase_t phase;
    logic   parity, start_ok;

    mesh_pe_phase_ctrl #(
        .ROWS        (ROWS),
        .COLS        (COLS),
        .SORT_CYCLES (SORT_CYCLES),
        .CNT_W       (CNT_W)
    ) u_ctrl (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .phase     (phase),
        .parity    (parity),
        .start_ok  (start_ok),
        .busy      (busy),
        .done      (done),
        .inst_addr (inst_addr)
    );

    pkt_t own, own_nxt, res_q, res_nxt, nbr;
    pkt_t nl, nr, nu, nd;
    logic res_valid_nxt, conflict_nxt;
    logic deliver, want_down, want_up, want_right, want_left;

    assign nl = pkt_t'(i_l);
    assign nr = pkt_t'(i_r);
    assign nu = pkt_t'(i_u);
    assign nd = pkt_t'(i_d);

    assign deliver    = own.valid && (own.key == SELF_KEY);
    assign want_down  = own.valid && (tgt_row(32'(own.key), COL_BITS) > ROW_U);
    assign want_up    = own.valid && (tgt_row(32'(own.key), COL_BITS) < ROW_U);
    assign want_right = own.valid && (tgt_row(32'(own.key), COL_BITS) == ROW_U)
                        && (tgt_col(32'(own.key), COL_BITS) > COL_U);
    assign want_left  = own.valid && (tgt_row(32'(own.key), COL_BITS) == ROW_U)
                        && (tgt_col(32'(own.key), COL_BITS) < COL_U);

    always_comb begin
        case (inst[1:0])
            DIR_L:   nbr = nl;
            DIR_R:   nbr = nr;
            DIR_U:   nbr = nu;
            default: nbr = nd;
        endcase
    end

    // A PE only gives when the receiver is empty and only takes when itself empty; the
    // parity picks one direction per cycle so both ends of a link agree.
    always_comb begin
        own_nxt       = own;
        res_nxt       = res_q;
        res_valid_nxt = res_valid;
        conflict_nxt  = conflict;
        case (phase)
            IDLE: begin
                if (load_valid) own_nxt = '{valid: 1'b1, key: load_key, data: load_data};
                if (start) begin
                    res_valid_nxt = 1'b0;
                    conflict_nxt  = 1'b0;
                end
            end
            SORT: begin
                case (inst[3:2])
                    OP_TAKE: own_nxt = nbr;
                    OP_TAKE_IF_LT:
                        if (key_lt(own.valid, 32'(own.key), nbr.valid, 32'(nbr.key))) own_nxt = nbr;
                    OP_TAKE_IF_GT:
                        if (key_lt(nbr.valid, 32'(nbr.key), own.valid, 32'(own.key))) own_nxt = nbr;
                    default: ;
                endcase
            end
            ROW_ALIGN: begin
                if (!parity) begin
                    if (want_down && !nd.valid)
                        own_nxt = '0;
                    else if (!own.valid && nu.valid && tgt_row(32'(nu.key), COL_BITS) >= ROW_U)
                        own_nxt = nu;
                end else begin
                    if (want_up && !nu.valid)
                        own_nxt = '0;
                    else if (!own.valid && nd.valid && tgt_row(32'(nd.key), COL_BITS) <= ROW_U)
                        own_nxt = nd;
                end
            end
            COL_ALIGN: begin
                if (deliver) begin
                    own_nxt = '0;
                    if (res_valid) begin
                        conflict_nxt = 1'b1;
                    end else begin
                        res_nxt       = own;
                        res_valid_nxt = 1'b1;
                    end
                end else if (!parity) begin
                    if (want_right && !nr.valid)
                        own_nxt = '0;
                    else if (!own.valid && nl.valid && tgt_row(32'(nl.key), COL_BITS) == ROW_U
                             && tgt_col(32'(nl.key), COL_BITS) >= COL_U)
                        own_nxt = nl;
                end else begin
                    if (want_left && !nl.valid)
                        own_nxt = '0;
                    else if (!own.valid && nr.valid && tgt_row(32'(nr.key), COL_BITS) == ROW_U
                             && tgt_col(32'(nr.key), COL_BITS) <= COL_U)
                        own_nxt = nr;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            own       <= '0;
            res_q     <= '0;
            res_valid <= 1'b0;
            conflict  <= 1'b0;
        end else begin
            own       <= own_nxt;
            res_q     <= res_nxt;
            res_valid <= res_valid_nxt;
            conflict  <= conflict_nxt;
        end
    end

    assign o_pkt   = own;
    assign res_pkt = res_q;

`ifdef MESH_PE_STALL_CNT_EN
    logic stall_hit;

    always_comb begin
        stall_hit = 1'b0;
        case (phase)
            ROW_ALIGN: stall_hit = parity ? (want_up && nu.valid) : (want_down && nd.valid);
            COL_ALIGN: stall_hit = parity ? (want_left && nl.valid) : (want_right && nr.valid);
            default:   ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst || start_ok)
            stall_cnt <= '0;
        else if (stall_hit && stall_cnt != 16'hFFFF)
            stall_cnt <= stall_cnt + 16'd1;
    end
`else
    logic unused_start_ok;
    assign unused_start_ok = start_ok;
`endif

endmodule

// File: tb/tb_mesh_sort_pe.sv
// Self-checking bench for mesh_sort_pe as PE (1,2) of a 4x4 mesh: reset, load, sort vectors,
// row/column alignment, delivery conflict, run latency, mid-run reset, optional stall counter.
module tb_mesh_sort_pe;

    localparam int KW = 4;
    localparam int DW = 8;
    localparam int PW = 1 + KW + DW;

    logic          clk = 1'b0;
    logic          rst;
    logic          start, load_valid;
    logic [KW-1:0] load_key;
    logic [DW-1:0] load_data;
    logic [3:0]    inst;
    logic [7:0]    inst_addr;
    logic [PW-1:0] i_l, i_r, i_u, i_d, o_pkt, res_pkt;
    logic          busy, done, res_valid, conflict;
`ifdef MESH_PE_STALL_CNT_EN
    logic [15:0]   stall_cnt;
`endif

    mesh_sort_pe #(
        .ROWS(4), .COLS(4), .ROW(1), .COL(2),
        .KEY_W(KW), .DATA_W(DW), .SORT_CYCLES(10), .CNT_W(8)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .load_valid (load_valid),
        .load_key   (load_key),
        .load_data  (load_data),
        .inst       (inst),
        .inst_addr  (inst_addr),
        .i_l        (i_l),
        .i_r        (i_r),
        .i_u        (i_u),
        .i_d        (i_d),
        .o_pkt      (o_pkt),
        .busy       (busy),
        .done       (done),
        .res_valid  (res_valid),
        .res_pkt    (res_pkt),
        .conflict   (conflict)
`ifdef MESH_PE_STALL_CNT_EN
        ,
        .stall_cnt  (stall_cnt)
`endif
    );

    always #5 clk = ~clk;

    int n_pass  = 0;
    int n_total = 0;

    typedef struct {
        string         name;
        logic [3:0]    inst;
        logic [PW-1:0] nbr;
        logic [PW-1:0] exp_pkt;
    } vec_t;

    vec_t          vecs[8];
    logic [PW-1:0] exp_q[$];
    logic [PW-1:0] exp_pkt;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    endtask

    function automatic logic [PW-1:0] pk(input logic v, input logic [KW-1:0] k, input logic [DW-1:0] d);
        return {v, k, d};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        rst = 1'b0;
    endtask

    task automatic clear_inputs();
        start = 1'b0; load_valid = 1'b0; load_key = '0; load_data = '0;
        inst = 4'b0000; i_l = '0; i_r = '0; i_u = '0; i_d = '0;
    endtask

    initial begin
        clear_inputs();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        check("rst_o_pkt", 32'(o_pkt), 32'd0);
        check("rst_res_pkt", 32'(res_pkt), 32'd0);
        check("rst_res_valid", 32'(res_valid), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_conflict", 32'(conflict), 32'd0);
        check("rst_inst_addr", 32'(inst_addr), 32'd0);

        // Idle load.
        load_valid = 1'b1; load_key = 4'd5; load_data = 8'h2A;
        tick();
        load_valid = 1'b0;
        check("load_o_pkt", 32'(o_pkt), 32'(pk(1'b1, 4'd5, 8'h2A)));
        check("load_busy", 32'(busy), 32'd0);
        check("load_done", 32'(done), 32'd0);

        // Sort step 0 vectors, own packet key 7 data 0x11.
        vecs[0] = '{"lt_r_take",    4'b0101, pk(1'b1, 4'd9, 8'h99), pk(1'b1, 4'd9, 8'h99)};
        vecs[1] = '{"gt_r_take",    4'b1001, pk(1'b1, 4'd3, 8'h33), pk(1'b1, 4'd3, 8'h33)};
        vecs[2] = '{"gt_r_inv",     4'b1001, '0,                    pk(1'b1, 4'd7, 8'h11)};
        vecs[3] = '{"lt_r_inv",     4'b0101, '0,                    '0};
        vecs[4] = '{"take_l",       4'b1100, pk(1'b1, 4'd2, 8'h22), pk(1'b1, 4'd2, 8'h22)};
        vecs[5] = '{"hold_u",       4'b0010, pk(1'b1, 4'd1, 8'h44), pk(1'b1, 4'd7, 8'h11)};
        vecs[6] = '{"lt_d_equal",   4'b0111, pk(1'b1, 4'd7, 8'h77), pk(1'b1, 4'd7, 8'h11)};
        vecs[7] = '{"gt_u_take",    4'b1010, pk(1'b1, 4'd4, 8'h55), pk(1'b1, 4'd4, 8'h55)};

        for (int v = 0; v < 8; v++) begin
            do_reset();
            start = 1'b1; load_valid = 1'b1; load_key = 4'd7; load_data = 8'h11;
            tick();
            start = 1'b0; load_valid = 1'b0;
            if (v == 0) check("sort_inst_addr0", 32'(inst_addr), 32'd0);
            inst = vecs[v].inst;
            case (vecs[v].inst[1:0])
                2'b00:   i_l = vecs[v].nbr;
                2'b01:   i_r = vecs[v].nbr;
                2'b10:   i_u = vecs[v].nbr;
                default: i_d = vecs[v].nbr;
            endcase
            exp_q.push_back(vecs[v].exp_pkt);
            tick();
            exp_pkt = exp_q.pop_front();
            check(vecs[v].name, 32'(o_pkt), 32'(exp_pkt));
            if (v == 0) check("sort_inst_addr1", 32'(inst_addr), 32'd1);
            clear_inputs();
        end

        // Odd row cycle: packet from above must not be taken.
        do_reset();
        start = 1'b1;
        tick();
        start = 1'b0;
        repeat (11) tick();
        i_u = pk(1'b1, 4'd6, 8'h66);
        tick();
        i_u = '0;
        check("row_odd_no_take", 32'(o_pkt), 32'd0);

        // Even row cycle capture, then delivery and conflict in the column phase.
        do_reset();
        start = 1'b1;
        tick();
        start = 1'b0;
        repeat (10) tick();
        check("row_busy", 32'(busy), 32'd1);
        i_u = pk(1'b1, 4'd6, 8'h66);
        tick();
        i_u = '0;
        check("row_even_take", 32'(o_pkt), 32'(pk(1'b1, 4'd6, 8'h66)));
        repeat (3) tick();
        check("col_pre_hold", 32'(o_pkt), 32'(pk(1'b1, 4'd6, 8'h66)));
        check("col_pre_res_valid", 32'(res_valid), 32'd0);
        tick();
        check("deliver_res_valid", 32'(res_valid), 32'd1);
        check("deliver_res_pkt", 32'(res_pkt), 32'(pk(1'b1, 4'd6, 8'h66)));
        check("deliver_o_pkt", 32'(o_pkt), 32'd0);
        i_r = pk(1'b1, 4'd6, 8'h77);
        tick();
        i_r = '0;
        check("col_odd_take_r", 32'(o_pkt), 32'(pk(1'b1, 4'd6, 8'h77)));
        tick();
        check("conflict_set", 32'(conflict), 32'd1);
        check("conflict_res_kept", 32'(res_pkt), 32'(pk(1'b1, 4'd6, 8'h66)));
        check("conflict_o_pkt", 32'(o_pkt), 32'd0);
        tick();
        check("done_pulse", 32'(done), 32'd1);
        tick();
        check("done_clear", 32'(done), 32'd0);
        check("res_valid_held", 32'(res_valid), 32'd1);

        // Run latency, with a start+load attempted while busy.
        do_reset();
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int i = 1; i <= 20; i++) begin
            check($sformatf("lat_busy_c%0d", i), 32'(busy), 32'(i <= 18));
            check($sformatf("lat_done_c%0d", i), 32'(done), 32'(i == 19));
            if (i == 5) begin
                start = 1'b1; load_valid = 1'b1; load_key = 4'd3; load_data = 8'hC3;
            end else begin
                start = 1'b0; load_valid = 1'b0;
            end
            tick();
            if (i == 5) check("busy_load_ignored", 32'(o_pkt), 32'd0);
        end

        // Reset in the middle of the row phase.
        start = 1'b1; load_valid = 1'b1; load_key = 4'd6; load_data = 8'h5A;
        tick();
        clear_inputs();
        repeat (12) tick();
        check("mid_busy", 32'(busy), 32'd1);
        check("mid_o_pkt", 32'(o_pkt), 32'(pk(1'b1, 4'd6, 8'h5A)));
        do_reset();
        check("mid_rst_o_pkt", 32'(o_pkt), 32'd0);
        check("mid_rst_busy", 32'(busy), 32'd0);
        check("mid_rst_done", 32'(done), 32'd0);
        check("mid_rst_res_valid", 32'(res_valid), 32'd0);
        tick();
        check("mid_rst_stays_idle", 32'(busy), 32'd0);

`ifdef MESH_PE_STALL_CNT_EN
        // Key 15 wants to move down but the PE below is occupied.
        do_reset();
        start = 1'b1; load_valid = 1'b1; load_key = 4'd15; load_data = 8'hF0;
        tick();
        clear_inputs();
        check("stall_start_clear", 32'(stall_cnt), 32'd0);
        repeat (10) tick();
        i_d = pk(1'b1, 4'd0, 8'h01);
        tick();
        check("stall_even1", 32'(stall_cnt), 32'd1);
        check("stall_blocked_pkt", 32'(o_pkt), 32'(pk(1'b1, 4'd15, 8'hF0)));
        tick();
        check("stall_odd", 32'(stall_cnt), 32'd1);
        tick();
        tick();
        check("stall_even2", 32'(stall_cnt), 32'd2);
        i_d = '0;
        do_reset();
        check("stall_rst", 32'(stall_cnt), 32'd0);
`endif

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
